// File: rtl/config_spi_if_if.sv
// Bundle of the serial host pins and the register-bank side of config_spi_if.
// The slave modport is the converter; the master modport is the host plus bank.
interface config_spi_if_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16
);
  logic              sclk;
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic              reg_write;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic [DATA_W-1:0] reg_rdata;
  logic              frame_err;

  modport master (
    output sclk, cs_n, mosi, reg_rdata,
    input  miso, reg_write, reg_addr, reg_wdata, frame_err
  );

  modport slave (
    input  sclk, cs_n, mosi, reg_rdata,
    output miso, reg_write, reg_addr, reg_wdata, frame_err
  );
endinterface

// File: rtl/config_spi_if.sv
// SPI mode-0 host interface: turns 24-bit frames (8-bit command + data) into
// single-cycle register writes and shifts register read data back out on miso.
module config_spi_if #(
  parameter int ADDR_W      = 3,
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           reset,
  config_spi_if_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W + 9);
  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(7);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(DATA_W + 7);

  typedef enum logic [1:0] {IDLE, CMD, DATA, WAIT} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, cs_prev_q;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [6:0]        cmd_sh_q, cmd_sh_d;
  logic              is_wr_q, is_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rd_sh_q, rd_sh_d;
  logic              miso_q, miso_d;
  logic              write_q, write_d;
  logic              err_q, err_d;
  logic [1:0]        upd_q, upd_d;

  logic sclk_s, cs_s, mosi_s;
  logic cs_fall, cs_rise, edge_en, sclk_rise, sclk_fall;

  assign sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
  assign cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], bus.cs_n};
  assign mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign cs_fall = cs_prev_q & ~cs_s;
  assign cs_rise = ~cs_prev_q & cs_s;
  // Keep edges live in the cycle cs_n rises so a coincident final bit still completes.
  assign edge_en   = ~cs_s | cs_rise;
  assign sclk_rise = edge_en & sclk_s & ~sclk_prev_q;
  assign sclk_fall = edge_en & ~sclk_s & sclk_prev_q;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cs_fall) state_d = CMD;
      CMD: begin
        if (cs_rise)                               state_d = IDLE;
        else if (sclk_rise && cnt_q == CMD_LAST)   state_d = DATA;
      end
      DATA: begin
        if (sclk_rise && cnt_q == FRAME_LAST)      state_d = WAIT;
        else if (cs_rise)                          state_d = IDLE;
      end
      WAIT: if (cs_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    cmd_sh_d = cmd_sh_q;
    is_wr_d  = is_wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd_sh_d  = rd_sh_q;
    miso_d   = miso_q;
    write_d  = 1'b0;
    err_d    = 1'b0;
    upd_d    = {upd_q[0], 1'b0};
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        miso_d = 1'b0;
      end
      CMD: begin
        miso_d = 1'b0;
        if (cs_rise) begin
          err_d = 1'b1;
        end else if (sclk_rise) begin
          cnt_d    = cnt_q + 1'b1;
          cmd_sh_d = {cmd_sh_q[5:0], mosi_s};
          if (cnt_q == CMD_LAST) begin
            is_wr_d  = cmd_sh_q[6];
            addr_d   = {cmd_sh_q[ADDR_W-2:0], mosi_s};
            upd_d[0] = 1'b1;
          end
        end
      end
      DATA: begin
        if (sclk_rise) begin
          cnt_d = cnt_q + 1'b1;
          if (is_wr_q) wdata_d = {wdata_q[DATA_W-2:0], mosi_s};
        end
        if (sclk_rise && cnt_q == FRAME_LAST) begin
          write_d = is_wr_q;
          miso_d  = 1'b0;
        end else if (cs_rise) begin
          err_d  = 1'b1;
          miso_d = 1'b0;
        end else if (sclk_fall && !is_wr_q) begin
          miso_d  = rd_sh_q[DATA_W-1];
          rd_sh_d = {rd_sh_q[DATA_W-2:0], 1'b0};
        end
      end
      WAIT: miso_d = 1'b0;
      default: miso_d = 1'b0;
    endcase
    // Bank output is registered: sample it two cycles after the address moves.
    if (upd_q[1]) rd_sh_d = bus.reg_rdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
      cnt_q       <= '0;
      cmd_sh_q    <= '0;
      is_wr_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_sh_q     <= '0;
      miso_q      <= 1'b0;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      upd_q       <= '0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      cnt_q       <= cnt_d;
      cmd_sh_q    <= cmd_sh_d;
      is_wr_q     <= is_wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_sh_q     <= rd_sh_d;
      miso_q      <= miso_d;
      write_q     <= write_d;
      err_q       <= err_d;
      upd_q       <= upd_d;
    end
  end

  assign bus.miso      = miso_q;
  assign bus.reg_write = write_q;
  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.frame_err = err_q;

endmodule

// File: doc/config_spi_if.md
# config_spi_if

SPI-style serial host interface that sits directly upstream of the configuration register bank (`config_reg`). It converts 24-bit serial frames from an external host into single-cycle register writes, and it serialises register read data back to the host. The host clock is oversampled by the system clock.

## Interface
- `ADDR_W`, default 3: register address width. Covers the eight bank registers, adc0_reg (0) through digital_config (7).
- `DATA_W`, default 16: register data width.
- `SYNC_STAGES`, default 2: number of synchroniser flops on `sclk`, `cs_n` and `mosi`.

Ports (clock and reset first):
- `clk`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  reset, synchronous and active-low. All state clears on a `clk` edge while `reset`=0.
- `sclk`  in  1  host serial clock, asynchronous to `clk`.
- `cs_n`  in  1  host chip select, active-low; frames a transaction.
- `mosi`  in  1  host serial data in, MSB first.
- `miso`  out  1  serial read data to the host, MSB first.
- `reg_write`  out  1  one-cycle write strobe to the register bank.
- `reg_addr`  out  ADDR_W  register address to the bank; held between frames.
- `reg_wdata`  out  DATA_W  write data to the bank; valid while `reg_write`=1.
- `reg_rdata`  in  DATA_W  bank read data for `reg_addr`.
- `frame_err`  out  1  one-cycle pulse when a frame is aborted.

## Operation
- **Frame layout:** 8-bit command followed by 16 data bits, 24 bits total.
  - Command bit 7: 1 = write, 0 = read.
  - Command bits 6:3: reserved, ignored.
  - Command bits 2:0: address.
- **Sampling:** mosi is sampled on rising `sclk` edges. miso changes on falling `sclk` edges (SPI mode 0).
- **Synchronisers and edge detect:** the inputs pass through `SYNC_STAGES` flops. Rising and falling edges of `sclk` are detected from the synchronised value, and edge pulses are only acted on while the synchronised `cs_n` is 0.
- **State machine:**
  - **IDLE:** bit counter cleared. A falling edge on the synchronised `cs_n` moves to CMD.
  - **CMD:** shift in 8 bits. After the 8th rising edge, latch the command, drive `reg_addr` from command bits 2:0, and move to DATA.
  - **DATA:** shift in 16 bits into `reg_wdata`'s shift register.
    - Write frame: after the 24th rising edge, pulse `reg_write` for exactly one cycle with `reg_wdata` valid, then go to WAIT.
    - Read frame: incoming mosi bits are ignored. After the 24th rising edge, go to WAIT.
  - **WAIT:** ignore all further `sclk` edges until the synchronised `cs_n` returns to 1, then go to IDLE.
- **Read path:**
  - Two cycles after `reg_addr` updates, capture `reg_rdata` into a 16-bit output shift register. The two cycles cover a registered bank output.
  - On each falling `sclk` edge in DATA, drive `miso` with shift[15], then shift left.
  - `miso` is 0 in IDLE and CMD, during write frames, and in WAIT.
- **Abort:** if the synchronised `cs_n` rises in CMD or DATA before bit 24:
  - `reg_write` is not asserted.
  - `frame_err` pulses for one cycle.
  - The state returns to IDLE.
  - `reg_addr` keeps its last value.
- **Extra bits:** `sclk` edges beyond bit 24 within one frame have no effect.
- **Reset mid-frame:** the state returns to IDLE and the partial frame is discarded. No write and no `frame_err` result from it.

## Timing
- **Reset values:** `miso`=0, `reg_write`=0, `reg_addr`=0, `reg_wdata`=0, `frame_err`=0, state IDLE, counters 0.
- **`sclk` rate:** each `sclk` high and low phase must be at least 4 `clk` cycles. `cs_n` setup to the first `sclk` edge, and hold after the last, must each be at least 4 `clk` cycles.
- **Edge-detect latency:** an edge is detected `SYNC_STAGES`+1 cycles after the pin transition (3 cycles at the default).
- **Write latency:** `reg_write` asserts on the cycle after the 24th rising edge is detected, for exactly one cycle.
- **Address update:** `reg_addr` updates on the cycle after the 8th rising edge is detected.
- **Read capture:** `reg_rdata` is captured 2 cycles after the `reg_addr` update. This is always before the next falling edge, which is detected at least 4 cycles later.
- **Read data on the wire:** the first read bit (bit 15) appears on `miso` on the cycle after the falling edge that follows command bit 0 is detected.
- **Abort timing:** `frame_err` pulses on the cycle after the `cs_n` rise is detected.
- **Simultaneous events:** if a `cs_n` rise and the 24th rising edge are detected in the same cycle, the frame completes. The write is issued and `frame_err` stays 0.
- **Back-to-back frames:** supported with `cs_n` high for at least 4 cycles between frames.

## Test plan
- **Reset:** hold `reset`=0 for 2 cycles mid-stream → all outputs 0, and the following frame decodes correctly.
- **Single write:** write frame with command 0x85, data 0xABCD → exactly one `reg_write` cycle with `reg_addr`=5 and `reg_wdata`=0xABCD; `miso` stays 0.
- **Single read:** read frame with command 0x04 and `reg_rdata`=0x1234 → host samples 0x1234 MSB first; `reg_addr`=4; `reg_write` never asserts.
- **Abort:** `cs_n` high after 12 bits of a write → no `reg_write`, one-cycle `frame_err`, `reg_addr` unchanged; a full write to address 2 with data 0x8000 then succeeds.
- **Reset mid-frame:** reset after 10 bits → no write and no `frame_err`; a subsequent read of address 0 returns the `reg_rdata` value presented.
- **Sweep and extra bits:** write all 8 addresses back-to-back with data 0x0000, 0xFFFF, 0x0001 and 0x0010, and 4 extra `sclk` edges per frame → one write per frame with the correct address and data; extra edges are ignored.
